// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 binary32 divider using bit-serial restoring mantissa division.
// Define FP32_DIV_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp32_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        exception,
    output logic        overflow,
    output logic        underflow,
    output logic [31:0] res
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND
    } state_t;

    state_t state, state_next;

    logic [4:0]  cnt;
    logic [24:0] rem;
    logic [25:0] quo;
    logic [23:0] mb;
    logic [7:0]  ea, eb;
    logic        sign;

    // one restoring-division step
    logic        qbit;
    logic [24:0] rem_sub;

    // normalisation / rounding
    logic signed [9:0] exp_base, exp_norm, exp_fin;
    logic [22:0] mant_norm, mant_fin;

    // result selection
    logic [31:0] res_c;
    logic        exc_c, ovf_c, unf_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DIV;
            DIV:     if (cnt == 5'd25) state_next = ROUND;
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        qbit    = (rem >= {1'b0, mb});
        rem_sub = qbit ? (rem - {1'b0, mb}) : rem;
    end

    always_comb begin
        exp_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (quo[25]) begin
            mant_norm = quo[24:2];
            exp_norm  = exp_base;
        end else begin
            mant_norm = quo[23:1];
            exp_norm  = exp_base - 10'sd1;
        end
    end

`ifdef FP32_DIV_ROUND_EN
    logic        guard, sticky, round_up;
    logic [23:0] mant_sum;

    always_comb begin
        if (quo[25]) begin
            guard  = quo[1];
            sticky = quo[0] | (|rem);
        end else begin
            guard  = quo[0];
            sticky = |rem;
        end
        round_up = guard & (sticky | mant_norm[0]);
        mant_sum = {1'b0, mant_norm} + {23'b0, round_up};
        // an all-ones mantissa rolling over leaves mant_sum[22:0] at zero already
        mant_fin = mant_sum[22:0];
        exp_fin  = mant_sum[23] ? (exp_norm + 10'sd1) : exp_norm;
    end
`else
    always_comb begin
        mant_fin = mant_norm;
        exp_fin  = exp_norm;
    end
`endif

    always_comb begin
        res_c = '0;
        exc_c = 1'b0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (ea == 8'hFF || eb == 8'hFF || eb == 8'h00) begin
            exc_c = 1'b1;
        end else if (ea == 8'h00) begin
            res_c = {sign, 31'b0};
        end else if (exp_fin >= 10'sd255) begin
            ovf_c = 1'b1;
            res_c = {sign, 8'hFF, 23'b0};
        end else if (exp_fin <= 10'sd0) begin
            unf_c = 1'b1;
            res_c = {sign, 31'b0};
        end else begin
            res_c = {sign, exp_fin[7:0], mant_fin};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            exception <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            res       <= '0;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            mb        <= '0;
            ea        <= '0;
            eb        <= '0;
            sign      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        ea   <= a[30:23];
                        eb   <= b[30:23];
                        sign <= a[31] ^ b[31];
                        rem  <= {2'b01, a[22:0]};
                        mb   <= {1'b1, b[22:0]};
                        quo  <= '0;
                        cnt  <= '0;
                    end
                end
                DIV: begin
                    rem <= rem_sub << 1;
                    quo <= {quo[24:0], qbit};
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    res       <= res_c;
                    exception <= exc_c;
                    overflow  <= ovf_c;
                    underflow <= unf_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized traffic. Honours FP32_DIV_ROUND_EN like the RTL.
module tb_fp32_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, exception, overflow, underflow;
    logic [31:0] res;

    fp32_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow),
        .res       (res)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned edge_cnt = 0;
    int          done_count = 0;
    bit          chk_en = 1'b0;

    // expected state: {exception, overflow, underflow, res}
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [34:0] m_out = '0;
    logic [34:0] pending = '0;
    int          remaining = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // Quotient bits are floor(ma * 2^25 / mb); the division remainder gives sticky.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
        logic   s;
        int     ex, ey, e;
        longint ma, mbv, num, q, mant;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if (ex == 255 || ey == 255 || ey == 0) return {3'b100, 32'h0};
        if (ex == 0) return {3'b000, s, 31'h0};
        ma  = longint'({1'b1, x[22:0]});
        mbv = longint'({1'b1, y[22:0]});
        num = ma << 25;
        q   = num / mbv;
        e   = ex - ey + 127;
        if (q >= 33554432) begin
            mant = (q >> 2) & 64'h7FFFFF;
        end else begin
            mant = (q >> 1) & 64'h7FFFFF;
            e    = e - 1;
        end
`ifdef FP32_DIV_ROUND_EN
        begin : rnd
            bit g, st;
            if (q >= 33554432) begin
                g  = q[1];
                st = q[0] || ((num % mbv) != 0);
            end else begin
                g  = q[0];
                st = (num % mbv) != 0;
            end
            if (g && (st || mant[0])) begin
                mant++;
                if (mant == 8388608) begin
                    mant = 0;
                    e++;
                end
            end
        end
`endif
        if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b001, s, 31'h0};
        return {3'b000, s, 8'(e), 23'(mant)};
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned sel;
        logic [31:0] r;
        sel = $urandom_range(0, 15);
        r = $urandom;
        case (sel)
            0:       r[30:23] = 8'h00;
            1:       r[30:23] = 8'hFF;
            2:       r[30:23] = 8'($urandom_range(1, 12));
            3:       r[30:23] = 8'($urandom_range(240, 254));
            4:       r[22:0]  = 23'h0;
            5:       r[22:0]  = 23'h7FFFFF;
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    // Behavioural timing: result lands 27 edges after acceptance, starts ignored meanwhile.
    always @(posedge clk) begin
        edge_cnt++;
        if (!rst_n) begin
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_out     = '0;
            remaining = 0;
        end else begin
            m_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_out  = pending;
                end
            end else if (start === 1'b1) begin
                remaining = 27;
                m_busy    = 1'b1;
                pending   = model(a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs", {27'b0, busy, done, exception, overflow, underflow, res},
                  {27'b0, m_busy, m_done, m_out});
            if (done === 1'b1) done_count++;
        end
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (m_busy && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (m_busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic launch(input logic [31:0] x, input logic [31:0] y, output int unsigned n);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = edge_cnt;
    endtask

    task automatic wait_done(output int unsigned at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = edge_cnt;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic directed(input string name, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_res, input logic [2:0] exp_flags);
        int unsigned n, at;
        bit ok;
        check({name, "_model"}, 64'(model(x, y)), 64'({exp_flags, exp_res}));
        wait_idle();
        launch(x, y, n);
        wait_done(at, ok);
        check({name, "_done_seen"}, 64'(ok), 64'd1);
        check({name, "_latency"}, 64'(at - n), 64'd27);
        check({name, "_res"}, 64'(res), 64'(exp_res));
        check({name, "_flags"}, 64'({exception, overflow, underflow}), 64'(exp_flags));
    endtask

    initial begin
        int unsigned n, at, at2;
        bit ok;
        int d0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_state", {27'b0, busy, done, exception, overflow, underflow, res}, 64'd0);
        rst_n = 1'b1;

        directed("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);
        directed("neg_ten_div_five", 32'hC120_0000, 32'h40A0_0000, 32'hC000_0000, 3'b000);
`ifdef FP32_DIV_ROUND_EN
        directed("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 3'b000);
`else
        directed("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000);
`endif
        directed("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 3'b010);
        directed("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 3'b001);
        directed("inf_dividend", 32'h7F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b100);
        directed("div_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 3'b100);
        directed("zero_dividend", 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000);

        // start while busy is ignored
        wait_idle();
        launch(32'h3F80_0000, 32'h4000_0000, n);
        d0 = done_count;
        repeat (4) @(negedge clk);
        start = 1'b1;
        a = 32'h40C0_0000;
        b = 32'h4000_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("busy_start_one_done", 64'(done_count - d0), 64'd1);
        check("busy_start_res", 64'(res), 64'h3F00_0000);

        // back-to-back at the earliest accepting edge
        wait_idle();
        launch(32'h40C0_0000, 32'h4000_0000, n);
        wait_done(at, ok);
        start = 1'b1;
        a = 32'hC120_0000;
        b = 32'h40A0_0000;
        @(negedge clk);
        start = 1'b0;
        wait_done(at2, ok);
        check("b2b_done_seen", 64'(ok), 64'd1);
        check("b2b_latency", 64'(at2 - n), 64'd55);
        check("b2b_res", 64'(res), 64'hC000_0000);

        // reset mid-operation aborts it
        wait_idle();
        launch(32'h3F80_0000, 32'h4040_0000, n);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_outputs", {27'b0, busy, done, exception, overflow, underflow, res}, 64'd0);
        rst_n = 1'b1;
        d0 = done_count;
        repeat (35) @(negedge clk);
        check("abort_no_done", 64'(done_count - d0), 64'd0);
        directed("after_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);

        // randomized traffic, including starts while busy and back-to-back requests
        d0 = done_count;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a = rand_fp();
            b = rand_fp();
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("random_ops_ran", 64'(done_count - d0 > 80), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
